// File: rtl/icache_responder_if.sv
// Fetch-side and memory-controller-side signals of the instruction cache.
// The slave modport is the cache. The master modport is the fetcher plus the memory controller.
interface icache_responder_if;
  logic        IF_pc_sgn;
  logic [31:0] IF_pc;
  logic        IF_ins_sgn;
  logic [31:0] IF_ins;
  logic        MC_req;
  logic [31:0] MC_addr;
  logic        MC_done;
  logic [31:0] MC_data;

  modport slave (
    input  IF_pc_sgn, IF_pc, MC_done, MC_data,
    output IF_ins_sgn, IF_ins, MC_req, MC_addr
  );

  modport master (
    output IF_pc_sgn, IF_pc, MC_done, MC_data,
    input  IF_ins_sgn, IF_ins, MC_req, MC_addr
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache with 4-word lines.
// Hits answer in one cycle. Misses refill one word at a time from the memory controller.
module icache_responder #(
  parameter int IDX_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                flush,
  icache_responder_if.slave   bus
);
  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {IDLE, REFILL, GAP} state_t;

  state_t             state_reg;
  logic [1:0]         k_reg;
  logic [31:2]        pc_reg;
  logic               flush_seen_reg;
  logic [LINES-1:0]   valid_reg;
  logic               ins_sgn_reg;
  logic [31:0]        ins_reg;
  logic               mc_req_reg;
  logic [31:0]        mc_addr_reg;

  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [31:0]        data_mem [LINES*4];
  logic [31:0]        fill_buf [4];

  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [1:0]         req_off;
  logic [IDX_W-1:0]   fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic [1:0]         fill_off;
  logic               hit;
  logic               fill_we;
  logic               fill_last;
  logic [31:0]        fill_word;
  logic               unused_pc_bits;

  assign req_idx   = bus.IF_pc[3+IDX_W:4];
  assign req_tag   = bus.IF_pc[31:4+IDX_W];
  assign req_off   = bus.IF_pc[3:2];
  assign fill_idx  = pc_reg[3+IDX_W:4];
  assign fill_tag  = pc_reg[31:4+IDX_W];
  assign fill_off  = pc_reg[3:2];
  assign hit       = valid_reg[req_idx] && (tag_mem[req_idx] == req_tag);
  assign fill_we   = rdy && !rst && (state_reg == REFILL) && bus.MC_done;
  assign fill_last = (k_reg == 2'd3);
  // The last word arrives in the same cycle as the response, so it bypasses the buffer.
  assign fill_word = (fill_off == 2'd3) ? bus.MC_data : fill_buf[fill_off];
  assign unused_pc_bits = ^bus.IF_pc[1:0];

  // Line storage is not reset. Only the valid bits guard it.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_mem[{fill_idx, k_reg}] <= bus.MC_data;
      fill_buf[k_reg]             <= bus.MC_data;
      if (fill_last) begin
        tag_mem[fill_idx] <= fill_tag;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg[gi] <= 1'b0;
        end else if (fill_we && fill_last && (fill_idx == IDX_W'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      k_reg          <= 2'd0;
      pc_reg         <= '0;
      flush_seen_reg <= 1'b0;
      ins_sgn_reg    <= 1'b0;
      ins_reg        <= '0;
      mc_req_reg     <= 1'b0;
      mc_addr_reg    <= '0;
    end else if (rdy) begin
      ins_sgn_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.IF_pc_sgn) begin
            if (hit) begin
              ins_sgn_reg <= 1'b1;
              ins_reg     <= data_mem[{req_idx, req_off}];
            end else begin
              pc_reg         <= bus.IF_pc[31:2];
              k_reg          <= 2'd0;
              flush_seen_reg <= 1'b0;
              mc_req_reg     <= 1'b1;
              mc_addr_reg    <= {bus.IF_pc[31:4], 4'b0000};
              state_reg      <= REFILL;
            end
          end
        end
        REFILL: begin
          if (flush) begin
            flush_seen_reg <= 1'b1;
          end
          if (bus.MC_done) begin
            mc_req_reg <= 1'b0;
            k_reg      <= k_reg + 2'd1;
            if (fill_last) begin
              state_reg <= IDLE;
              // A redirect since the miss means the fetcher no longer wants this word.
              if (!flush_seen_reg && !flush) begin
                ins_sgn_reg <= 1'b1;
                ins_reg     <= fill_word;
              end
            end else begin
              state_reg <= GAP;
            end
          end
        end
        GAP: begin
          if (flush) begin
            flush_seen_reg <= 1'b1;
          end
          mc_req_reg  <= 1'b1;
          mc_addr_reg <= {pc_reg[31:4], k_reg, 2'b00};
          state_reg   <= REFILL;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.IF_ins_sgn = ins_sgn_reg;
  assign bus.IF_ins     = ins_reg;
  assign bus.MC_req     = mc_req_reg;
  assign bus.MC_addr    = mc_addr_reg;
endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder. A scoreboard holds the expected refill addresses and responses.
// A small memory-controller model answers each word request two cycles after it rises.
module tb_icache_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic flush = 1'b0;
  logic mc_en = 1'b1;
  logic force_done = 1'b0;
  logic model_done = 1'b0;
  int   model_cnt = 0;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic prev_req = 1'b0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t        ins_q[$];
  logic [31:0] addr_q[$];

  icache_responder_if bus();

  icache_responder #(.IDX_W(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign bus.MC_done = model_done | force_done;
  assign bus.MC_data = mem_word(bus.MC_addr);

  always @(posedge clk) begin
    if (rst || !mc_en) begin
      model_cnt  <= 0;
      model_done <= 1'b0;
    end else begin
      model_done <= 1'b0;
      if (bus.MC_req && !model_done) begin
        if (model_cnt == 1) begin
          model_done <= 1'b1;
          model_cnt  <= 0;
        end else begin
          model_cnt <= model_cnt + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Refill addresses are checked on each rising MC_req, responses on each IF_ins_sgn pulse.
  always @(negedge clk) begin
    exp_t e;
    if (bus.MC_req === 1'b1 && prev_req !== 1'b1) begin
      $display("cyc %0d: MC request addr=%h", cyc, bus.MC_addr);
      check("mc_req_expected", 32'(addr_q.size() != 0), 32'd1);
      if (addr_q.size() != 0) check("mc_addr", bus.MC_addr, addr_q.pop_front());
    end
    prev_req = bus.MC_req;
    if (bus.IF_ins_sgn === 1'b1) begin
      $display("cyc %0d: IF response ins=%h", cyc, bus.IF_ins);
      check("ins_expected", 32'(ins_q.size() != 0), 32'd1);
      if (ins_q.size() != 0) begin
        e = ins_q.pop_front();
        check("ins_data", bus.IF_ins, e.data);
        if (e.cyc >= 0) check("ins_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] pc);
    bus.IF_pc_sgn = 1'b1;
    bus.IF_pc     = pc;
    step();
    bus.IF_pc_sgn = 1'b0;
  endtask

  task automatic push_line(input logic [31:0] pc);
    for (int k = 0; k < 4; k++) addr_q.push_back({pc[31:4], 2'(k), 2'b00});
  endtask

  task automatic push_ins(input int c, input logic [31:0] pc);
    exp_t e;
    e.cyc  = c;
    e.data = mem_word({pc[31:2], 2'b00});
    ins_q.push_back(e);
  endtask

  // An uninterrupted miss answers 16 cycles after the request.
  task automatic do_miss(input logic [31:0] pc);
    push_line(pc);
    push_ins(cyc + 16, pc);
    req(pc);
    repeat (16) step();
  endtask

  task automatic hit(input logic [31:0] pc);
    push_ins(cyc + 1, pc);
    req(pc);
  endtask

  initial begin
    int n;
    bus.IF_pc_sgn = 1'b0;
    bus.IF_pc     = '0;
    repeat (2) step();
    rst = 1'b0;
    check("rst_ins_sgn", 32'(bus.IF_ins_sgn), 32'd0);
    check("rst_ins", bus.IF_ins, 32'd0);
    check("rst_mc_req", 32'(bus.MC_req), 32'd0);
    check("rst_mc_addr", bus.MC_addr, 32'd0);

    // Cold miss, then streaming hits on the same line
    do_miss(32'h100);
    for (int i = 1; i < 4; i++) begin
      hit(32'h100 + 32'(4 * i));
      check("stream_mc_req", 32'(bus.MC_req), 32'd0);
    end
    step();
    check("stream_end_sgn", 32'(bus.IF_ins_sgn), 32'd0);

    // Flush with redirect to a cached PC
    flush = 1'b1;
    hit(32'h100);
    flush = 1'b0;
    step();
    check("redirect_single_pulse", 32'(bus.IF_ins_sgn), 32'd0);

    // Conflict eviction on the same index, then the address boundary
    do_miss(32'h500);
    do_miss(32'h100);
    do_miss(32'hFFFF_FFF4);

    // Flush after the second completion: line installed, no response
    push_line(32'h200);
    n = cyc;
    req(32'h200);
    while (cyc < n + 8) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    while (cyc < n + 17) step();
    hit(32'h204);
    step();

    // rdy stall during word 1 while MC_done toggles
    push_line(32'h300);
    n = cyc;
    push_ins(n + 20, 32'h300);
    req(32'h300);
    while (cyc < n + 6) step();
    check("pre_stall_addr", bus.MC_addr, 32'h304);
    rdy   = 1'b0;
    mc_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      force_done = (i != 1);
      step();
      check("stall_mc_req", 32'(bus.MC_req), 32'd1);
      check("stall_mc_addr", bus.MC_addr, 32'h304);
    end
    force_done = 1'b0;
    rdy        = 1'b1;
    mc_en      = 1'b1;
    while (cyc < n + 21) step();

    // Reset mid-refill abandons it and invalidates every line
    addr_q.push_back(32'h600);
    req(32'h600);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_mc_req", 32'(bus.MC_req), 32'd0);
    check("rst_mid_ins_sgn", 32'(bus.IF_ins_sgn), 32'd0);
    do_miss(32'h104);

    repeat (3) step();
    check("ins_queue_drained", 32'(ins_q.size()), 32'd0);
    check("addr_queue_drained", 32'(addr_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
